// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with RAM-wait watchdog and sticky FAULT.
// 3-5 cycles per instruction plus RAM wait; FETCH/MEM stall on mem_ready, outputs are zero while in reset.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CONST_W     = 26,
    parameter int FS_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst,
    input  logic [3:0]         status,
    input  logic               alu_z,
    input  logic               mem_ready,
    output logic [4:0]         DA,
    output logic [4:0]         AA,
    output logic [4:0]         BA,
    output logic [CONST_W-1:0] Const,
    output logic [FS_W-1:0]    FS,
    output logic [1:0]         PC_SEL,
    output logic               WR,
    output logic               WRR,
    output logic               RR,
    output logic               RCS,
    output logic               EN_ALU,
    output logic               EN_B,
    output logic               EN_K,
    output logic               EN_ADDR_ALU,
    output logic               EN_ADDR_PC,
    output logic               IL,
    output logic               Cin,
    output logic               SFL,
    output logic [2:0]         state,
    output logic               fault
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [4:0] F_ADD = 5'b01000;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd7
    } st_t;

    typedef enum logic [4:0] {
        OP_BAD, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR,
        OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND, OP_BR
    } op_t;

    st_t              cur_st, nxt_st;
    op_t              op_q, dec_op;
    logic [25:0]      ir_q;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out;
    logic             cond_taken;
    logic             unused_carry;

    function automatic op_t decode(input logic [10:0] o);
        op_t r;
        casez (o)
            11'b10001011000: r = OP_ADD;
            11'b10101011000: r = OP_ADDS;
            11'b11001011000: r = OP_SUB;
            11'b11101011000: r = OP_SUBS;
            11'b10001010000: r = OP_AND;
            11'b10101010000: r = OP_ORR;
            11'b11001010000: r = OP_EOR;
            11'b11010011011: r = OP_LSL;
            11'b11010011010: r = OP_LSR;
            11'b1001000100?: r = OP_ADDI;
            11'b1101000100?: r = OP_SUBI;
            11'b11111000010: r = OP_LDUR;
            11'b11111000000: r = OP_STUR;
            11'b000101?????: r = OP_B;
            11'b100101?????: r = OP_BL;
            11'b10110100???: r = OP_CBZ;
            11'b10110101???: r = OP_CBNZ;
            11'b01010100???: r = OP_BCOND;
            11'b11010110000: r = OP_BR;
            default:         r = OP_BAD;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] fs_code(input op_t op);
        logic [4:0] f;
        case (op)
            OP_SUB, OP_SUBS, OP_SUBI: f = 5'b01001;
            OP_AND:                   f = 5'b00000;
            OP_ORR:                   f = 5'b00100;
            OP_EOR:                   f = 5'b01100;
            OP_LSL:                   f = 5'b10000;
            OP_LSR:                   f = 5'b10100;
            default:                  f = F_ADD;
        endcase
        return f;
    endfunction

    assign dec_op    = decode(inst[31:21]);
    assign timed_out = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign state     = cur_st;
    // Carry is not consulted by any supported condition code.
    assign unused_carry = status[1];

    always_comb begin
        case (ir_q[3:0])
            4'b0000: cond_taken = status[2];
            4'b0001: cond_taken = !status[2];
            4'b1010: cond_taken = (status[3] == status[0]);
            4'b1011: cond_taken = (status[3] != status[0]);
            4'b1100: cond_taken = !status[2] && (status[3] == status[0]);
            4'b1101: cond_taken = status[2] || (status[3] != status[0]);
            4'b1110: cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= S_FETCH;
            op_q   <= OP_BAD;
            ir_q   <= '0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            run_q  <= 1'b1;
            cur_st <= nxt_st;
            cnt_q  <= cnt_d;
            if (cur_st == S_DECODE) begin
                op_q <= dec_op;
                ir_q <= inst[25:0];
            end
        end
    end

    always_comb begin
        nxt_st = cur_st;
        cnt_d  = '0;
        DA = '0; AA = '0; BA = '0; Const = '0; FS = '0; PC_SEL = 2'b00;
        WR = 1'b0; WRR = 1'b0; RR = 1'b0; RCS = 1'b0; EN_ALU = 1'b0; EN_B = 1'b0;
        EN_K = 1'b0; EN_ADDR_ALU = 1'b0; EN_ADDR_PC = 1'b0; IL = 1'b0; Cin = 1'b0; SFL = 1'b0;
        fault = 1'b0;
        case (cur_st)
            S_FETCH: if (run_q) begin
                if (timed_out) begin
                    nxt_st = S_FAULT;
                end else begin
                    EN_ADDR_PC = 1'b1; RCS = 1'b1; RR = 1'b1;
                    if (mem_ready) begin
                        IL     = 1'b1;
                        nxt_st = S_DECODE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DECODE: nxt_st = (dec_op == OP_BAD) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                nxt_st = S_FETCH;
                case (op_q)
                    OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR,
                    OP_ADDI, OP_SUBI: begin
                        DA = ir_q[4:0]; AA = ir_q[9:5];
                        FS = FS_W'(fs_code(op_q));
                        EN_ALU = 1'b1; WR = 1'b1; PC_SEL = 2'b01;
                        Cin = op_q inside {OP_SUB, OP_SUBS, OP_SUBI};
                        SFL = op_q inside {OP_ADDS, OP_SUBS};
                        if (op_q inside {OP_ADDI, OP_SUBI}) begin
                            EN_K  = 1'b1;
                            Const = CONST_W'(ir_q[21:10]);
                        end else begin
                            BA = ir_q[20:16];
                        end
                    end
                    OP_LDUR, OP_STUR: nxt_st = S_MEM;
                    OP_B: begin
                        PC_SEL = 2'b10; Const = CONST_W'(ir_q[25:0]);
                    end
                    OP_BL: begin
                        PC_SEL = 2'b10; Const = CONST_W'(ir_q[25:0]);
                        WR = 1'b1; DA = 5'd30; EN_ADDR_PC = 1'b1;
                    end
                    OP_BR: begin
                        PC_SEL = 2'b11; AA = ir_q[9:5];
                    end
                    // Register is tested by adding a zero constant; only PC_SEL follows alu_z.
                    OP_CBZ, OP_CBNZ: begin
                        AA = ir_q[4:0]; FS = FS_W'(F_ADD); EN_K = 1'b1;
                        PC_SEL = ((op_q == OP_CBZ) == alu_z) ? 2'b10 : 2'b01;
                    end
                    OP_BCOND: begin
                        Const  = CONST_W'(ir_q[23:5]);
                        PC_SEL = cond_taken ? 2'b10 : 2'b01;
                    end
                    default: nxt_st = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (timed_out) begin
                    nxt_st = S_FAULT;
                end else begin
                    RCS = 1'b1; EN_ADDR_ALU = 1'b1; EN_K = 1'b1; FS = FS_W'(F_ADD);
                    AA = ir_q[9:5]; Const = CONST_W'(ir_q[20:12]);
                    if (op_q == OP_STUR) begin
                        WRR = 1'b1; EN_B = 1'b1; BA = ir_q[4:0];
                    end else begin
                        RR = 1'b1;
                    end
                    if (mem_ready) begin
                        if (op_q == OP_STUR) begin
                            PC_SEL = 2'b01;
                            nxt_st = S_FETCH;
                        end else begin
                            nxt_st = S_WB;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WB: begin
                WR = 1'b1; DA = ir_q[4:0]; PC_SEL = 2'b01;
                nxt_st = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: nxt_st = S_FAULT;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: each instruction is expanded into its expected per-cycle output trace and compared.
module tb_multicycle_control_unit;
    localparam int TMO = 16;
    localparam int K_ADD = 0, K_ADDS = 1, K_SUB = 2, K_SUBS = 3, K_AND = 4, K_ORR = 5, K_EOR = 6,
                   K_LSL = 7, K_LSR = 8, K_ADDI = 9, K_SUBI = 10, K_LDUR = 11, K_STUR = 12,
                   K_B = 13, K_BL = 14, K_CBZ = 15, K_CBNZ = 16, K_BC = 17, K_BR = 18, K_BAD = 19;
    localparam logic [11:0] M_WR = 12'h800, M_WRR = 12'h400, M_RR = 12'h200, M_RCS = 12'h100,
                            M_ALU = 12'h080, M_EB = 12'h040, M_EK = 12'h020, M_EAA = 12'h010,
                            M_EAP = 12'h008, M_IL = 12'h004, M_CIN = 12'h002, M_SFL = 12'h001;

    typedef struct packed {
        logic [4:0]  da, aa, ba;
        logic [25:0] k;
        logic [4:0]  fs;
        logic [1:0]  pcs;
        logic [11:0] stb;
        logic [2:0]  st;
        logic        flt;
    } out_t;

    typedef struct packed {
        logic mr;
        logic dec;
        out_t exp;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic [3:0]  status = '0;
    logic        alu_z = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  DA, AA, BA;
    logic [25:0] Const;
    logic [4:0]  FS;
    logic [1:0]  PC_SEL;
    logic        WR, WRR, RR, RCS, EN_ALU, EN_B, EN_K, EN_ADDR_ALU, EN_ADDR_PC, IL, Cin, SFL;
    logic [2:0]  state;
    logic        fault;
    out_t        obs;

    int          n_vec = 0;
    int          n_bad = 0;
    cyc_t        q[$];
    logic [31:0] cur_inst;
    bit          faulted;

    multicycle_control_unit #(.MEM_TIMEOUT(TMO), .CONST_W(26), .FS_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .status(status), .alu_z(alu_z), .mem_ready(mem_ready),
        .DA(DA), .AA(AA), .BA(BA), .Const(Const), .FS(FS), .PC_SEL(PC_SEL),
        .WR(WR), .WRR(WRR), .RR(RR), .RCS(RCS), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_K(EN_K),
        .EN_ADDR_ALU(EN_ADDR_ALU), .EN_ADDR_PC(EN_ADDR_PC), .IL(IL), .Cin(Cin), .SFL(SFL),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    assign obs = {DA, AA, BA, Const, FS, PC_SEL,
                  WR, WRR, RR, RCS, EN_ALU, EN_B, EN_K, EN_ADDR_ALU, EN_ADDR_PC, IL, Cin, SFL,
                  state, fault};

    task automatic check(input string tag, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input int k, input logic [31:0] r);
        logic [31:0] w;
        w = r;
        case (k)
            K_ADD:  w[31:21] = 11'b10001011000;
            K_ADDS: w[31:21] = 11'b10101011000;
            K_SUB:  w[31:21] = 11'b11001011000;
            K_SUBS: w[31:21] = 11'b11101011000;
            K_AND:  w[31:21] = 11'b10001010000;
            K_ORR:  w[31:21] = 11'b10101010000;
            K_EOR:  w[31:21] = 11'b11001010000;
            K_LSL:  w[31:21] = 11'b11010011011;
            K_LSR:  w[31:21] = 11'b11010011010;
            K_ADDI: w[31:22] = 10'b1001000100;
            K_SUBI: w[31:22] = 10'b1101000100;
            K_LDUR: w[31:21] = 11'b11111000010;
            K_STUR: w[31:21] = 11'b11111000000;
            K_B:    w[31:26] = 6'b000101;
            K_BL:   w[31:26] = 6'b100101;
            K_CBZ:  w[31:24] = 8'b10110100;
            K_CBNZ: w[31:24] = 8'b10110101;
            K_BC:   w[31:24] = 8'b01010100;
            K_BR:   w[31:21] = 11'b11010110000;
            default: w[31:21] = 11'b0;
        endcase
        return w;
    endfunction

    function automatic logic [4:0] fs_of(input int k);
        case (k)
            K_SUB, K_SUBS, K_SUBI: return 5'b01001;
            K_AND: return 5'b00000;
            K_ORR: return 5'b00100;
            K_EOR: return 5'b01100;
            K_LSL: return 5'b10000;
            K_LSR: return 5'b10100;
            default: return 5'b01000;
        endcase
    endfunction

    function automatic bit taken(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic mr, input logic dec, input out_t o);
        cyc_t c;
        c.mr = mr; c.dec = dec; c.exp = o;
        c.exp.flt = (o.st == 3'd7);
        q.push_back(c);
    endtask

    task automatic push_fault();
        out_t o;
        o = '0; o.st = 3'd7;
        for (int i = 0; i < 3; i++) push(1'($urandom), 1'b0, o);
        faulted = 1'b1;
    endtask

    // Expected trace of one instruction: fetch waits, IL, decode, execute, memory waits, write-back.
    task automatic plan(input int k, input logic [31:0] w, input int fw, input int mw,
                        input logic z, input logic [3:0] f);
        out_t o;
        faulted = 1'b0;
        o = '0; o.stb = M_RCS | M_RR | M_EAP;
        for (int c = 0; c < fw && c < TMO; c++) push(1'b0, 1'b0, o);
        if (fw >= TMO) begin
            push(1'b0, 1'b0, out_t'('0));
            push_fault();
            return;
        end
        o.stb |= M_IL;
        push(1'b1, 1'b0, o);
        o = '0; o.st = 3'd1;
        push(1'($urandom), 1'b1, o);
        if (k == K_BAD) begin
            push_fault();
            return;
        end
        o = '0; o.st = 3'd2;
        if (k <= K_SUBI) begin
            o.da = w[4:0]; o.aa = w[9:5]; o.fs = fs_of(k); o.pcs = 2'b01;
            o.stb = M_WR | M_ALU;
            if (k == K_ADDI || k == K_SUBI) begin
                o.stb |= M_EK; o.k = 26'(w[21:10]);
            end else begin
                o.ba = w[20:16];
            end
            if (k == K_SUB || k == K_SUBS || k == K_SUBI) o.stb |= M_CIN;
            if (k == K_ADDS || k == K_SUBS) o.stb |= M_SFL;
        end else if (k == K_B || k == K_BL) begin
            o.pcs = 2'b10; o.k = w[25:0];
            if (k == K_BL) begin o.da = 5'd30; o.stb = M_WR | M_EAP; end
        end else if (k == K_BR) begin
            o.pcs = 2'b11; o.aa = w[9:5];
        end else if (k == K_CBZ || k == K_CBNZ) begin
            o.aa = w[4:0]; o.fs = 5'b01000; o.stb = M_EK;
            o.pcs = ((k == K_CBZ) ? z : !z) ? 2'b10 : 2'b01;
        end else if (k == K_BC) begin
            o.k = 26'(w[23:5]); o.pcs = taken(w[3:0], f) ? 2'b10 : 2'b01;
        end
        push(1'($urandom), 1'b0, o);
        if (k != K_LDUR && k != K_STUR) return;
        o = '0; o.st = 3'd3; o.aa = w[9:5]; o.k = 26'(w[20:12]); o.fs = 5'b01000;
        o.stb = M_RCS | M_EAA | M_EK;
        if (k == K_STUR) begin o.stb |= M_WRR | M_EB; o.ba = w[4:0]; end
        else o.stb |= M_RR;
        for (int c = 0; c < mw && c < TMO; c++) push(1'b0, 1'b0, o);
        if (mw >= TMO) begin
            o = '0; o.st = 3'd3;
            push(1'b0, 1'b0, o);
            push_fault();
            return;
        end
        if (k == K_STUR) o.pcs = 2'b01;
        push(1'b1, 1'b0, o);
        if (k == K_LDUR) begin
            o = '0; o.st = 3'd4; o.da = w[4:0]; o.pcs = 2'b01; o.stb = M_WR;
            push(1'($urandom), 1'b0, o);
        end
    endtask

    task automatic run_plan(input string tag, input int limit);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            c = q.pop_front();
            mem_ready = c.mr;
            inst = c.dec ? cur_inst : $urandom;
            @(negedge clk);
            check(tag, obs, c.exp);
            @(posedge clk); #1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b1; inst = $urandom;
        @(negedge clk);
        check("reset", obs, out_t'('0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_cycle", obs, out_t'('0));
        @(posedge clk); #1;
    endtask

    task automatic do_inst(input string tag, input int k, input logic [31:0] w, input int fw,
                           input int mw, input logic z, input logic [3:0] f);
        cur_inst = w; alu_z = z; status = f;
        plan(k, w, fw, mw, z, f);
        run_plan(tag, 1000);
        if (faulted) do_reset();
    endtask

    initial begin
        int k, fw, mw;
        do_reset();
        do_inst("addi",   K_ADDI, 32'h91001441, 0, 0, 1'b0, 4'h0);
        do_inst("subs",   K_SUBS, 32'hEB020023, 1, 0, 1'b0, 4'h0);
        do_inst("ldur",   K_LDUR, mk_inst(K_LDUR, $urandom), 0, 3, 1'b0, 4'h0);
        do_inst("stur",   K_STUR, mk_inst(K_STUR, $urandom), 2, 1, 1'b0, 4'h0);
        do_inst("cbz_t",  K_CBZ,  mk_inst(K_CBZ, $urandom), 0, 0, 1'b1, 4'h0);
        do_inst("cbz_n",  K_CBZ,  mk_inst(K_CBZ, $urandom), 0, 0, 1'b0, 4'h0);
        do_inst("cbnz_t", K_CBNZ, mk_inst(K_CBNZ, $urandom), 0, 0, 1'b0, 4'h0);
        do_inst("bgt_t",  K_BC,   32'h5400000C, 0, 0, 1'b0, 4'b0000);
        do_inst("bgt_n",  K_BC,   32'h5400000C, 0, 0, 1'b0, 4'b1000);
        do_inst("bl",     K_BL,   mk_inst(K_BL, $urandom), 0, 0, 1'b0, 4'h0);
        do_inst("br",     K_BR,   mk_inst(K_BR, $urandom), 0, 0, 1'b0, 4'h0);
        do_inst("fetch_15", K_ADD, mk_inst(K_ADD, $urandom), TMO - 1, 0, 1'b0, 4'h0);
        do_inst("fetch_tmo", K_ADD, mk_inst(K_ADD, $urandom), TMO, 0, 1'b0, 4'h0);
        do_inst("mem_tmo", K_LDUR, mk_inst(K_LDUR, $urandom), 0, TMO, 1'b0, 4'h0);
        do_inst("bad_op", K_BAD, 32'h0, 0, 0, 1'b0, 4'h0);

        cur_inst = mk_inst(K_STUR, $urandom);
        plan(K_STUR, cur_inst, 0, 5, 1'b0, 4'h0);
        run_plan("abort_pre", 5);
        rst_n = 1'b0;
        #1;
        check("abort", obs, out_t'('0));
        do_reset();

        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, K_BAD);
            fw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 12);
            mw = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 12);
            do_inst($sformatf("rand%0d_k%0d", i, k), k, mk_inst(k, $urandom), fw, mw,
                    1'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
